instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch stage (IF plus IF/ID register) directly upstream of the main control decoder.
//  Owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
//  Presents {pc, instr, opcode} to decode, honours decode stalls, and takes beq redirects.
//  if_opcode (instr[31:26]) drives the control decoder's opcode input.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded at reset; first fetch address
//  AW        32             imem_addr width; imem_addr = pc[AW-1:0]
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   asynchronous, active-low reset (0 = reset)
//  imem_req       out  1   fetch request; held with imem_addr stable until imem_ack
//  imem_addr      out  AW  word-aligned fetch address
//  imem_ack       in   1   response valid this cycle (latency >= 0 cycles after req)
//  imem_rdata     in   32  instruction word, valid when imem_ack=1
//  stall          in   1   decode cannot accept; hold the current IF/ID contents
//  redirect_valid in   1   one-cycle pulse: taken branch, flush and refetch
//  redirect_pc    in   32  new PC, sampled when redirect_valid=1
//  if_valid       out  1   IF/ID holds a real instruction
//  if_pc          out  32  PC of if_instr
//  if_pc_plus4    out  32  if_pc + 4, for the branch adder
//  if_instr       out  32  instruction word; 32'h0 (nop) when if_valid=0
//  if_opcode      out  6   if_instr[31:26]; feeds the control decoder
//  fetch_misalign out  1   sticky: a redirect_pc had bits[1:0] != 0
// BEHAVIOUR
//  Reset (reset=0, asynchronous): pc=RESET_PC, imem_req=0, if_valid=0, if_pc=0, if_instr=0,
//   skid empty, fetch_misalign=0, state=FETCH. First request goes out in the first cycle after release.
//  One outstanding request at most. Arithmetic is modulo 2^32; pc+4 wraps 32'hFFFF_FFFC -> 0.
//  Buffer: 2 entries, IF/ID output register plus 1 skid entry. The output is consumed when if_valid && !stall.
//  FSM states:
//   FETCH: imem_req=1 only while the skid is empty.
//    On ack, the word goes to the output if it is empty or being consumed; otherwise it goes to the skid. pc<=pc+4.
//   DROP: a redirect arrived while a request was outstanding without ack.
//    imem_req stays 1 with the old address. The acked word is discarded, then the FSM goes to FETCH.
//  Skid drain: when the output is consumed and the skid is valid, skid moves to the output in the same cycle.
//   The next request is issued that cycle, so back-to-back ack=1 with stall=0 gives 1 instruction/cycle.
//  Redirect (has priority over stall and ack):
//   if_valid<=0, if_instr<=0, skid cleared, pc<={redirect_pc[31:2],2'b00}.
//   If misaligned, fetch_misalign<=1.
//   If imem_req=1 and imem_ack=0 that cycle, go to DROP. If ack is in the same cycle, the data is discarded and the FSM goes to FETCH.
//  Redirect during DROP: update pc, stay in DROP. Only one ack is discarded.
//  stall with if_valid=0: ignored; the output may fill.
//  Reset mid-request: abandoned. The memory side must tolerate req dropping before ack.
//  Outputs are registered; if_opcode and if_pc_plus4 are combinational from registers only.
// STRUCTURE
//  mips_pkg: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_BEQ=6'b000100, NOP_INSTR=32'h0,
//   fetch FSM state encoding (FETCH, DROP), INSTR_W=32, OPC_W=6.
//  Sub-module fetch_skid_buf: 2-entry {pc,instr} buffer with in_valid/in_ready, out_valid/out_ready, flush.
//  instr_fetch holds the PC, FSM and redirect logic.
// TESTING
//  1. Release reset, imem_ack=1 every cycle, rdata=pc-tagged words, stall=0
//     -> imem_addr 0,4,8,... ; if_valid from cycle 2; if_pc 0,4,8 back-to-back.
//  2. Stream in flight, stall=1 for 3 cycles -> if_pc frozen (e.g. 8), skid holds 12, imem_req=0.
//     Release stall -> 12 then 16 with no gap or duplicate.
//  3. Request at 0x10 with ack delayed 3 cycles, redirect_valid pulse with redirect_pc=0x40
//     -> req held at 0x10 until ack, word discarded, next imem_addr=0x40, first if_pc=0x40.
//  4. Redirect 0x80 in the same cycle as ack, stall=1 -> if_valid=0 next cycle, skid empty, next fetch at 0x80.
//  5. Redirect to 0x43 -> fetch at 0x40, fetch_misalign=1 until reset.
//     Assert reset mid-request -> all outputs zero, pc=RESET_PC.
//  6. rdata=32'h8C41_0004 (lw) -> if_opcode=6'b100011; a bubble gives if_opcode=6'b000000, if_instr=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end: opcodes, the nop word
// and the fetch FSM state encoding.
package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int OPC_W   = 6;

   localparam logic [OPC_W-1:0]   OP_RTYPE  = 6'b000000;
   localparam logic [OPC_W-1:0]   OP_LW     = 6'b100011;
   localparam logic [OPC_W-1:0]   OP_BEQ    = 6'b000100;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DROP  = 1'b1
   } fetch_state_t;

   // Instruction memory is word addressed, so redirect targets are forced onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry {pc, instr} buffer between instruction memory and decode: the IF/ID
// output register plus one skid entry that catches a word arriving while decode stalls.
module fetch_skid_buf
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic               skid_empty_next
);

   logic               skid_valid;
   logic [31:0]        skid_pc;
   logic [INSTR_W-1:0] skid_instr;

   logic               out_valid_n;
   logic [31:0]        out_pc_n;
   logic [INSTR_W-1:0] out_instr_n;
   logic               skid_valid_n;
   logic [31:0]        skid_pc_n;
   logic [INSTR_W-1:0] skid_instr_n;
   logic               consume;
   logic               push;

   assign in_ready        = !skid_valid;
   assign consume         = out_valid && out_ready;
   assign push            = in_valid && in_ready;
   assign skid_empty_next = !skid_valid_n;

   // The output slot refills from the skid first, so ordering is preserved; an empty slot reads as nop.
   always_comb begin
      out_valid_n  = out_valid;
      out_pc_n     = out_pc;
      out_instr_n  = out_instr;
      skid_valid_n = skid_valid;
      skid_pc_n    = skid_pc;
      skid_instr_n = skid_instr;
      if (flush) begin
         out_valid_n  = 1'b0;
         out_instr_n  = NOP_INSTR;
         skid_valid_n = 1'b0;
      end else if (!out_valid || consume) begin
         if (skid_valid) begin
            out_valid_n  = 1'b1;
            out_pc_n     = skid_pc;
            out_instr_n  = skid_instr;
            skid_valid_n = 1'b0;
         end else if (push) begin
            out_valid_n = 1'b1;
            out_pc_n    = in_pc;
            out_instr_n = in_instr;
         end else begin
            out_valid_n = 1'b0;
            out_instr_n = NOP_INSTR;
         end
      end else if (push) begin
         skid_valid_n = 1'b1;
         skid_pc_n    = in_pc;
         skid_instr_n = in_instr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_pc     <= 32'h0;
         out_instr  <= NOP_INSTR;
         skid_valid <= 1'b0;
         skid_pc    <= 32'h0;
         skid_instr <= NOP_INSTR;
      end else begin
         out_valid  <= out_valid_n;
         out_pc     <= out_pc_n;
         out_instr  <= out_instr_n;
         skid_valid <= skid_valid_n;
         skid_pc    <= skid_pc_n;
         skid_instr <= skid_instr_n;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// feeds the IF/ID register; taken branches flush the stage and refetch.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          AW       = 32
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [AW-1:0]      imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               if_valid,
   output logic [31:0]        if_pc,
   output logic [31:0]        if_pc_plus4,
   output logic [INSTR_W-1:0] if_instr,
   output logic [OPC_W-1:0]   if_opcode,
   output logic               fetch_misalign
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  pc_inc;
   logic [31:0]  redirect_target;
   logic         handshake;
   logic         buf_in_valid;
   logic         buf_in_ready;
   logic         skid_empty_next;

   assign pc_inc          = pc + 32'd4;
   assign redirect_target = align_word(redirect_pc);
   assign handshake       = imem_req && imem_ack;
   assign buf_in_valid    = (state == FETCH) && handshake && !redirect_valid && buf_in_ready;

   assign if_pc_plus4 = if_pc + 32'd4;
   assign if_opcode   = if_instr[31:26];

   fetch_skid_buf u_skid (
      .clk             (clk),
      .reset           (reset),
      .flush           (redirect_valid),
      .in_valid        (buf_in_valid),
      .in_ready        (buf_in_ready),
      .in_pc           (pc),
      .in_instr        (imem_rdata),
      .out_valid       (if_valid),
      .out_ready       (!stall),
      .out_pc          (if_pc),
      .out_instr       (if_instr),
      .skid_empty_next (skid_empty_next)
   );

   // imem_addr is kept apart from pc because an unacked request must hold its
   // old address while pc already points at the redirect target.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= FETCH;
         pc             <= RESET_PC;
         imem_req       <= 1'b0;
         imem_addr      <= RESET_PC[AW-1:0];
         fetch_misalign <= 1'b0;
      end else if (redirect_valid) begin
         pc <= redirect_target;
         if (redirect_pc[1:0] != 2'b00) begin
            fetch_misalign <= 1'b1;
         end
         if (state == DROP) begin
            if (imem_ack) begin
               state     <= FETCH;
               imem_req  <= 1'b1;
               imem_addr <= redirect_target[AW-1:0];
            end
         end else if (imem_req && !imem_ack) begin
            state <= DROP;
         end else begin
            imem_req  <= 1'b1;
            imem_addr <= redirect_target[AW-1:0];
         end
      end else begin
         case (state)
            DROP: begin
               if (imem_ack) begin
                  state     <= FETCH;
                  imem_req  <= 1'b1;
                  imem_addr <= pc[AW-1:0];
               end
            end
            default: begin
               imem_req <= skid_empty_next;
               if (handshake) begin
                  pc        <= pc_inc;
                  imem_addr <= pc_inc[AW-1:0];
               end else begin
                  imem_addr <= pc[AW-1:0];
               end
            end
         endcase
      end
   end

endmodule
